// File: rtl/ppi_mode1_hs_if.sv
// ppi_mode1_hs_if: control, CPU and peripheral signals of one mode-1 handshake channel
interface ppi_mode1_hs_if #(
    parameter int WIDTH = 8
);
    logic             mode1;
    logic             dir_in;
    logic             inte_wr;
    logic             inte_val;
    logic             cpu_rd;
    logic             cpu_wr;
    logic             nstb;
    logic             nack;
    logic [WIDTH-1:0] port_din;
    logic [WIDTH-1:0] data_q;
    logic             ibf;
    logic             nobf;
    logic             intr;
    logic             port_oe;
    logic             overrun;
    logic [2:0]       status;
    modport master (
        output mode1, dir_in, inte_wr, inte_val, cpu_rd, cpu_wr, nstb, nack, port_din,
        input  data_q, ibf, nobf, intr, port_oe, overrun, status
    );
    modport slave (
        input  mode1, dir_in, inte_wr, inte_val, cpu_rd, cpu_wr, nstb, nack, port_din,
        output data_q, ibf, nobf, intr, port_oe, overrun, status
    );
endinterface

// File: rtl/ppi_mode1_hs_ctrl.sv
// ppi_mode1_hs_ctrl: 8255-style mode-1 strobed handshake sequencer for one port channel.
// Define PPI_HS_SYNC_EN to pass nstb/nack through a two-flop synchronizer (+2 cycles latency).
module ppi_mode1_hs_ctrl #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    ppi_mode1_hs_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IN_WAIT, IN_FULL, OUT_EMPTY, OUT_FULL} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_ibf;
    logic             r_nobf;
    logic             r_intr;
    logic             r_oe;
    logic             r_ovr;
    logic             r_inte;
    logic             r_stb_p;
    logic             r_ack_p;
    logic             w_stb_s;
    logic             w_ack_s;
    logic             w_stb_fall;
    logic             w_stb_rise;
    logic             w_ack_fall;
    logic             w_ack_rise;
`ifdef PPI_HS_SYNC_EN
    logic [1:0] r_stb_sy;
    logic [1:0] r_ack_sy;
    always_ff @(posedge clk) begin
        r_stb_sy <= reset ? 2'b11 : {r_stb_sy[0], bus.nstb};
        r_ack_sy <= reset ? 2'b11 : {r_ack_sy[0], bus.nack};
    end
    assign w_stb_s = r_stb_sy[1];
    assign w_ack_s = r_ack_sy[1];
`else
    assign w_stb_s = bus.nstb;
    assign w_ack_s = bus.nack;
`endif
    // previous samples reset high so an idle pin never looks like an edge
    always_ff @(posedge clk) begin
        r_stb_p <= reset ? 1'b1 : w_stb_s;
        r_ack_p <= reset ? 1'b1 : w_ack_s;
    end
    assign w_stb_fall = r_stb_p & ~w_stb_s;
    assign w_stb_rise = ~r_stb_p & w_stb_s;
    assign w_ack_fall = r_ack_p & ~w_ack_s;
    assign w_ack_rise = ~r_ack_p & w_ack_s;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_ibf   <= 1'b0;
            r_nobf  <= 1'b1;
            r_intr  <= 1'b0;
            r_oe    <= 1'b0;
            r_ovr   <= 1'b0;
            r_inte  <= 1'b0;
        end else begin
            if (!bus.mode1) begin
                r_state <= IDLE;
                r_ibf   <= 1'b0;
                r_nobf  <= 1'b1;
                r_intr  <= 1'b0;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= bus.dir_in ? IN_WAIT : OUT_EMPTY;
                        r_oe    <= ~bus.dir_in;
                    end
                    IN_WAIT: if (w_stb_fall) begin
                        r_data  <= bus.port_din;
                        r_ibf   <= 1'b1;
                        r_state <= IN_FULL;
                    end
                    IN_FULL: if (w_stb_fall) begin
                        r_data <= bus.port_din;
                        r_ovr  <= 1'b1;
                        if (bus.cpu_rd) r_intr <= 1'b0;
                    end else begin
                        r_intr <= w_stb_rise ? r_inte : (bus.cpu_rd ? 1'b0 : r_intr);
                        if (bus.cpu_rd) begin
                            r_ibf   <= 1'b0;
                            r_state <= IN_WAIT;
                        end
                    end
                    OUT_EMPTY: if (bus.cpu_wr) begin
                        r_nobf  <= 1'b0;
                        r_intr  <= 1'b0;
                        r_state <= OUT_FULL;
                    end
                    OUT_FULL: if (w_ack_fall) begin
                        r_nobf <= 1'b1;
                    end else if (w_ack_rise) begin
                        r_nobf  <= 1'b1;
                        r_intr  <= r_inte;
                        r_state <= OUT_EMPTY;
                    end
                    default: r_state <= IDLE;
                endcase
            end
            if (bus.cpu_rd && !w_stb_fall) r_ovr <= 1'b0;
            // INTE writes land last so a clear always wins over a same-cycle interrupt
            if (bus.inte_wr) begin
                r_inte <= bus.inte_val;
                if (!bus.inte_val) r_intr <= 1'b0;
            end
        end
    end
    assign bus.data_q  = r_data;
    assign bus.ibf     = r_ibf;
    assign bus.nobf    = r_nobf;
    assign bus.intr    = r_intr;
    assign bus.port_oe = r_oe;
    assign bus.overrun = r_ovr;
    assign bus.status  = {r_intr, r_inte, r_ibf | ~r_nobf};
endmodule

// File: tb/tb_ppi_mode1_hs_ctrl.sv
// tb_ppi_mode1_hs_ctrl: directed handshake scenarios plus random traffic against a behavioural model.
// Latency expectations follow PPI_HS_SYNC_EN when it is defined for the build.
module tb_ppi_mode1_hs_ctrl;
`ifdef PPI_HS_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    ppi_mode1_hs_if #(.WIDTH(8)) bus ();
    ppi_mode1_hs_ctrl #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: pin history gives the sampled levels; channel tracked as active/direction/busy flags
    logic [3:0] m_sh, m_ah;
    logic [7:0] m_dq;
    logic m_active, m_in, m_busy, m_ibf, m_nobf, m_intr, m_oe, m_ovr, m_inte;
    task automatic model_step();
        logic fs, rs, fa, ra;
        m_sh = {m_sh[2:0], bus.nstb};
        m_ah = {m_ah[2:0], bus.nack};
        fs = m_sh[D+1] & ~m_sh[D];
        rs = ~m_sh[D+1] & m_sh[D];
        fa = m_ah[D+1] & ~m_ah[D];
        ra = ~m_ah[D+1] & m_ah[D];
        if (reset) begin
            m_sh = 4'hF; m_ah = 4'hF; m_dq = 8'h00;
            m_active = 0; m_in = 0; m_busy = 0; m_ibf = 0; m_nobf = 1;
            m_intr = 0; m_oe = 0; m_ovr = 0; m_inte = 0;
        end else begin
            if (!bus.mode1) begin
                m_active = 0; m_ibf = 0; m_nobf = 1; m_intr = 0; m_oe = 0;
            end else if (!m_active) begin
                m_active = 1; m_in = bus.dir_in; m_busy = 0; m_oe = !bus.dir_in;
            end else if (m_in) begin
                if (fs) begin
                    if (m_ibf) begin
                        m_ovr = 1;
                        if (bus.cpu_rd) m_intr = 0;
                    end
                    m_dq = bus.port_din;
                    m_ibf = 1;
                end else if (m_ibf) begin
                    if (rs) m_intr = m_inte;
                    else if (bus.cpu_rd) m_intr = 0;
                    if (bus.cpu_rd) m_ibf = 0;
                end
            end else if (!m_busy) begin
                if (bus.cpu_wr) begin
                    m_nobf = 0; m_intr = 0; m_busy = 1;
                end
            end else if (fa) begin
                m_nobf = 1;
            end else if (ra) begin
                m_nobf = 1; m_intr = m_inte; m_busy = 0;
            end
            if (bus.cpu_rd && !fs) m_ovr = 0;
            if (bus.inte_wr) begin
                m_inte = bus.inte_val;
                if (!bus.inte_val) m_intr = 0;
            end
        end
    endtask
    always @(posedge clk) model_step();
    always @(negedge clk) if (chk_en) begin
        chk("m_data_q", bus.data_q, m_dq);
        chk("m_ibf", bus.ibf, m_ibf);
        chk("m_nobf", bus.nobf, m_nobf);
        chk("m_intr", bus.intr, m_intr);
        chk("m_port_oe", bus.port_oe, m_oe);
        chk("m_overrun", bus.overrun, m_ovr);
        chk("m_status", bus.status, {m_intr, m_inte, m_ibf | ~m_nobf});
    end
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic idle();
        bus.mode1 = 0; bus.dir_in = 1; bus.inte_wr = 0; bus.inte_val = 0;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.nstb = 1; bus.nack = 1;
    endtask
    task automatic pulse_inte(input logic v);
        bus.inte_wr = 1; bus.inte_val = v;
        step();
        bus.inte_wr = 0;
    endtask
    task automatic rd_pulse();
        bus.cpu_rd = 1;
        step();
        bus.cpu_rd = 0;
    endtask
    task automatic strobe(input logic [7:0] d);
        bus.nstb = 0; bus.port_din = d;
        step(D + 2);
        bus.nstb = 1;
        step(D + 2);
    endtask
    initial begin
        reset = 1; bus.mode1 = 1; bus.dir_in = 1; bus.inte_wr = 1; bus.inte_val = 1;
        bus.cpu_rd = 1; bus.cpu_wr = 1; bus.nstb = 0; bus.nack = 0; bus.port_din = 8'hFF;
        step();
        chk_en = 1;
        chk("rst_data_q", bus.data_q, 8'h00);
        chk("rst_ibf", bus.ibf, 0);
        chk("rst_nobf", bus.nobf, 1);
        chk("rst_intr", bus.intr, 0);
        chk("rst_port_oe", bus.port_oe, 0);
        chk("rst_overrun", bus.overrun, 0);
        reset = 0;
        idle();
        step(3);
        bus.mode1 = 1; bus.dir_in = 1;
        pulse_inte(1);
        chk("in_oe", bus.port_oe, 0);
        chk("in_inte", bus.status[1], 1);
        bus.nstb = 0; bus.port_din = 8'hA5;
        repeat (D) begin step(); chk("in_ibf_latency", bus.ibf, 0); end
        step();
        chk("in_ibf", bus.ibf, 1);
        chk("in_data", bus.data_q, 8'hA5);
        step();
        bus.nstb = 1;
        repeat (D) begin step(); chk("in_intr_latency", bus.intr, 0); end
        step();
        chk("in_intr", bus.intr, 1);
        rd_pulse();
        chk("rd_intr", bus.intr, 0);
        chk("rd_ibf", bus.ibf, 0);
        pulse_inte(0);
        chk("inte_off", bus.status[1], 0);
        bus.nstb = 0; bus.port_din = 8'h5A;
        step(D + 2);
        bus.nstb = 1;
        chk("noint_ibf", bus.ibf, 1);
        chk("noint_data", bus.data_q, 8'h5A);
        step(D + 2);
        chk("noint_intr", bus.intr, 0);
        rd_pulse();
        chk("noint_rd_ibf", bus.ibf, 0);
        pulse_inte(1);
        strobe(8'hA5);
        strobe(8'h3C);
        chk("ovr_data", bus.data_q, 8'h3C);
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_ibf", bus.ibf, 1);
        bus.nstb = 0; bus.port_din = 8'h77;
        step(D);
        rd_pulse();
        chk("coin_ibf", bus.ibf, 1);
        chk("coin_data", bus.data_q, 8'h77);
        chk("coin_intr", bus.intr, 0);
        chk("coin_ovr", bus.overrun, 1);
        bus.nstb = 1;
        step(D + 2);
        rd_pulse();
        chk("ovr_clr_ibf", bus.ibf, 0);
        chk("ovr_clr", bus.overrun, 0);
        bus.mode1 = 0;
        step();
        bus.dir_in = 0; bus.mode1 = 1;
        pulse_inte(1);
        chk("out_oe", bus.port_oe, 1);
        chk("out_nobf_idle", bus.nobf, 1);
        bus.cpu_wr = 1; step(); bus.cpu_wr = 0;
        chk("wr_nobf", bus.nobf, 0);
        chk("wr_oe", bus.port_oe, 1);
        chk("wr_intr", bus.intr, 0);
        bus.nack = 0;
        repeat (D) begin step(); chk("ack_latency", bus.nobf, 0); end
        step();
        chk("ack_nobf", bus.nobf, 1);
        step();
        bus.nack = 1;
        repeat (D) begin step(); chk("ack_intr_latency", bus.intr, 0); end
        step();
        chk("ack_intr", bus.intr, 1);
        bus.cpu_wr = 1; step(); bus.cpu_wr = 0;
        chk("drop_pre_nobf", bus.nobf, 0);
        bus.mode1 = 0;
        step();
        chk("drop_nobf", bus.nobf, 1);
        chk("drop_oe", bus.port_oe, 0);
        chk("drop_intr", bus.intr, 0);
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            bus.mode1 = ($urandom_range(0, 63) != 0);
            bus.dir_in = 1'($urandom);
            bus.inte_wr = ($urandom_range(0, 15) == 0);
            bus.inte_val = 1'($urandom);
            bus.cpu_rd = ($urandom_range(0, 7) == 0);
            bus.cpu_wr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.nstb = ~bus.nstb;
            if ($urandom_range(0, 3) == 0) bus.nack = ~bus.nack;
            bus.port_din = 8'($urandom);
            step();
        end
        reset = 0;
        idle();
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
